identity_check_seq: RTL and testbench
=====================================

Name: identity_check_seq

Overview:
- Self-contained stimulus sequencer and comparator for identity (equivalence) runs between a golden design instance and a synthesized netlist instance.
- Generates the packed input vector `{wire3, wire2, wire1, wire0}` (64 bits) for both instances. Vector 0 is all-zero; later vectors come from an LFSR.
- Waits a programmable settle time, then compares the two 199-bit `y` buses.
- Counts mismatches, captures the first failing vector and its diff, and reports pass/fail.
- Replaces per-testbench hard-coded vector lists.

Parameters:
- IN_W, 64, width of the packed DUT input vector.
- OUT_W, 199, width of the compared DUT output `y`.
- NUM_VEC, 21, vectors per run, including the zero vector. Legal range 1..65535.
- SETTLE, 1, clock cycles each vector is held before compare. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the run; return to IDLE with no done pulse.
- seed  in  IN_W  LFSR seed, sampled on start.
- vec_out  out  IN_W  vector driven to both instances.
- vec_idx  out  16  index of the vector currently applied.
- y_ref  in  OUT_W  golden instance output.
- y_dut  in  OUT_W  synthesized instance output.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  err_cnt==0 at run end; held until the next start.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- first_idx  out  16  vec_idx of the first mismatch.
- first_diff  out  OUT_W  y_ref^y_dut at the first mismatch.
- sig  out  32  MISR signature (see Optional Feature).

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state=IDLE; vec_out=0; vec_idx=0.
  - busy=0; done=0; pass=0.
  - err_cnt=0; first_idx=0; first_diff=0.
  - LFSR=0; sig=32'hFFFFFFFF; settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, when start=1 at a clock edge:
  - Load LFSR with seed; seed 0 is replaced by 64'h1.
  - vec_out=0, vec_idx=0.
  - Clear err_cnt, first_idx, first_diff and pass; sig=32'hFFFFFFFF.
  - Go to SETTLE. start is ignored in every other state.
- SETTLE: hold vec_out for exactly SETTLE cycles, then go to CHECK.
- CHECK (one cycle): compare y_ref and y_dut.
  - If they differ: err_cnt increments, saturating.
  - If this is the first mismatch of the run (err_cnt==0 before increment): first_idx=vec_idx, first_diff=y_ref^y_dut.
  - If vec_idx==NUM_VEC-1: go to DONE.
  - Otherwise: vec_out=LFSR, LFSR advances, vec_idx+1, go to SETTLE.
- Vector sequence:
  - vector 0 = 0.
  - vector 1 = effective seed.
  - vector k+1 = step(vector k).
  - step is a Galois right shift: lsb=v[0]; v=v>>1; if lsb, v ^= 64'hD800_0000_0000_0000.
- Timing:
  - start sampled at edge 0.
  - Vector k is applied from edge 1+k*(SETTLE+1).
  - done is high for the single cycle following edge 1+NUM_VEC*(SETTLE+1).
- DONE (one cycle): done=1, pass=(err_cnt==0), go to IDLE.
  - vec_out, err_cnt, first_* and sig hold their values until the next start.
- busy = (state==SETTLE || state==CHECK).
- abort, any state other than IDLE:
  - Next state IDLE; done stays 0; pass=0.
  - Counters and captures are frozen.
  - abort has priority over every CHECK action in the same cycle.
- rst_n low mid-run: all outputs take their reset values immediately, regardless of clk.
- NUM_VEC=1: a run consists only of vector 0.

Optional Feature:
- Macro: IDCHK_MISR_SIG_EN.
- With the macro defined, on each CHECK cycle: sig = {sig[30:0], sig[31]} ^ fold32(y_dut).
  - fold32 = XOR of the 32-bit slices of y_dut, after zero-padding y_dut to 224 bits.
  - sig is initialised to 32'hFFFFFFFF on reset and on start.
  - This allows golden-signature comparison when no reference instance is present.
- Without the macro: sig is constant 32'h0 and no MISR logic is synthesized.

Test Plan:
- Equal outputs. NUM_VEC=4, SETTLE=2, y_ref=y_dut=0, start at edge 0.
  - Required: done high after edge 13; pass=1; err_cnt=0; busy high from edge 1 through edge 12.
- Vector sequence. seed=0.
  - Required: vec_out=0 at idx 0, 64'h1 at idx 1, 64'hD800_0000_0000_0000 at idx 2.
- Single mismatch. y_dut=y_ref^(1<<5) only while vec_idx==2; NUM_VEC=4.
  - Required: err_cnt=1, first_idx=2, first_diff=1<<5, pass=0.
- Repeated mismatch. y_dut differs at bit 198 on idx 1 and bit 0 on idx 3.
  - Required: err_cnt=2, first_idx=1, first_diff=1<<198.
- Abort and reset. abort asserted while vec_idx==1.
  - Required: IDLE next cycle, done never pulses, pass=0.
  - Then rst_n pulsed low between clock edges: all outputs reset asynchronously.
- MISR. IDCHK_MISR_SIG_EN defined, NUM_VEC=1, y_dut=0.
  - Required: sig=32'hFFFFFFFF.
  - With y_dut=1, NUM_VEC=1: sig=32'hFFFFFFFE.
  - Without the macro: sig=0.

Source files
------------

// File: rtl/identity_check_seq.sv
// Stimulus sequencer and y-bus comparator for golden-vs-netlist identity runs.
// Optional MISR signature on y_dut: define IDCHK_MISR_SIG_EN.
module identity_check_seq #(
  parameter int IN_W    = 64,
  parameter int OUT_W   = 199,
  parameter int NUM_VEC = 21,
  parameter int SETTLE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  output logic [IN_W-1:0]  vec_out,
  output logic [15:0]      vec_idx,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_idx,
  output logic [OUT_W-1:0] first_diff,
  output logic [31:0]      sig
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  localparam logic [IN_W-1:0] TAPS      = {5'b11011, {(IN_W-5){1'b0}}};
  localparam logic [15:0]     LAST_IDX  = 16'(NUM_VEC - 1);
  localparam logic [7:0]      SETTLE_LD = 8'(SETTLE - 1);

  state_t            r_state, w_state_nxt;
  logic              r_start_q;
  logic [IN_W-1:0]   r_lfsr, r_vec_out;
  logic [15:0]       r_vec_idx, r_err_cnt, r_first_idx;
  logic [OUT_W-1:0]  r_first_diff;
  logic [7:0]        r_settle_cnt;
  logic              r_done, r_pass;
  logic              w_mismatch, w_last;
  logic [15:0]       w_err_nxt;
  logic [IN_W-1:0]   w_lfsr_step;

  assign w_mismatch  = (y_ref != y_dut);
  assign w_last      = (r_vec_idx == LAST_IDX);
  assign w_err_nxt   = (w_mismatch && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_start_q) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                     w_state_nxt = ST_IDLE;
        else if (r_settle_cnt == 8'd0) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
        else             w_state_nxt = ST_SETTLE;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef IDCHK_MISR_SIG_EN
  localparam int FOLD_N = (OUT_W + 31) / 32;
  logic [FOLD_N*32-1:0] w_y_pad;
  logic [31:0]          w_fold;
  logic [31:0]          r_sig;

  always_comb begin
    w_y_pad = (FOLD_N*32)'(y_dut);
    w_fold  = 32'h0;
    for (int i = 0; i < FOLD_N; i++) w_fold = w_fold ^ w_y_pad[i*32 +: 32];
  end

  // Signature is cleared on start and advances only on uninterrupted compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_sig <= 32'hFFFF_FFFF;
    else if (r_state == ST_IDLE && r_start_q)   r_sig <= 32'hFFFF_FFFF;
    else if (r_state == ST_CHECK && !abort)     r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold;
  end
  assign sig = r_sig;
`else
  assign sig = 32'h0;
`endif

  // start is registered once so a run begins one edge after it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q    <= 1'b0;
      r_lfsr       <= '0;
      r_vec_out    <= '0;
      r_vec_idx    <= 16'd0;
      r_err_cnt    <= 16'd0;
      r_first_idx  <= 16'd0;
      r_first_diff <= '0;
      r_settle_cnt <= 8'd0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_start_q <= start && (r_state == ST_IDLE) && !r_start_q;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_start_q) begin
            r_lfsr       <= (seed == '0) ? IN_W'(1) : seed;
            r_vec_out    <= '0;
            r_vec_idx    <= 16'd0;
            r_err_cnt    <= 16'd0;
            r_first_idx  <= 16'd0;
            r_first_diff <= '0;
            r_pass       <= 1'b0;
            r_settle_cnt <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (abort)                      r_pass       <= 1'b0;
          else if (r_settle_cnt != 8'd0)  r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        ST_CHECK: begin
          if (abort) begin
            r_pass <= 1'b0;
          end else begin
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && r_err_cnt == 16'd0) begin
              r_first_idx  <= r_vec_idx;
              r_first_diff <= y_ref ^ y_dut;
            end
            if (w_last) begin
              r_done <= 1'b1;
              r_pass <= (w_err_nxt == 16'd0);
            end else begin
              r_vec_out    <= r_lfsr;
              r_lfsr       <= w_lfsr_step;
              r_vec_idx    <= r_vec_idx + 16'd1;
              r_settle_cnt <= SETTLE_LD;
            end
          end
        end
        ST_DONE: begin
          if (abort) r_pass <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign vec_out    = r_vec_out;
  assign vec_idx    = r_vec_idx;
  assign busy       = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign first_idx  = r_first_idx;
  assign first_diff = r_first_diff;

endmodule

// File: tb/tb_identity_check_seq.sv
// Bench for identity_check_seq: randomized runs checked against a vector/compare model.
module tb_identity_check_seq;
  localparam int IN_W = 64, OUT_W = 199, NV = 4, ST = 2;
  localparam int LAST_BUSY = NV * (ST + 1);
  localparam int DONE_E    = 1 + NV * (ST + 1);

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0, abort = 1'b0;
  logic [IN_W-1:0]  seed = '0;
  logic [IN_W-1:0]  vec_out;
  logic [15:0]      vec_idx, err_cnt, first_idx;
  logic [OUT_W-1:0] y_ref, y_dut, first_diff;
  logic             busy, done, pass;
  logic [31:0]      sig;

  logic             start1 = 1'b0;
  logic [IN_W-1:0]  vec_out1;
  logic [15:0]      vec_idx1, err_cnt1, first_idx1;
  logic [OUT_W-1:0] y_ref1, y_dut1 = '0, first_diff1;
  logic             busy1, done1, pass1;
  logic [31:0]      sig1;

  logic [OUT_W-1:0] inj [NV];
  logic [IN_W-1:0]  obs_vec [NV];
  int errors = 0, checks = 0;

  identity_check_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NV), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .vec_out(vec_out), .vec_idx(vec_idx), .y_ref(y_ref), .y_dut(y_dut),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_idx(first_idx), .first_diff(first_diff), .sig(sig));

  identity_check_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .seed(64'h0),
    .vec_out(vec_out1), .vec_idx(vec_idx1), .y_ref(y_ref1), .y_dut(y_dut1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .first_idx(first_idx1), .first_diff(first_diff1), .sig(sig1));

  // Stand-in for the two design instances: identical function, optional injected diff.
  function automatic logic [OUT_W-1:0] yf(input logic [IN_W-1:0] v);
    return {v, v, v, v[6:0]};
  endfunction

  always_comb begin
    y_ref = yf(vec_out);
    y_dut = y_ref;
    if (vec_idx < 16'(NV)) y_dut = y_ref ^ inj[vec_idx[1:0]];
  end
  assign y_ref1 = '0;

  function automatic logic [IN_W-1:0] step(input logic [IN_W-1:0] v);
    logic l;
    l = v[0];
    v = v >> 1;
    if (l) v = v ^ 64'hD800_0000_0000_0000;
    return v;
  endfunction

  function automatic logic [31:0] fold_bits(input logic [OUT_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] sig_expect(input logic [31:0] s);
`ifdef IDCHK_MISR_SIG_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  task automatic clear_inj();
    for (int k = 0; k < NV; k++) inj[k] = '0;
  endtask

  task automatic run_check(input logic [IN_W-1:0] sd, input string nm);
    logic [IN_W-1:0]  mv [NV];
    logic [IN_W-1:0]  cur;
    logic [OUT_W-1:0] e_fd;
    logic [15:0]      e_err, e_fi;
    logic [31:0]      s;
    int               k;
    mv[0] = '0;
    cur = (sd == '0) ? 64'h1 : sd;
    for (int j = 1; j < NV; j++) begin
      mv[j] = cur;
      cur = step(cur);
    end
    e_err = 0; e_fi = 0; e_fd = '0; s = 32'hFFFF_FFFF;
    for (int j = 0; j < NV; j++) begin
      if (inj[j] != '0) begin
        if (e_err == 0) begin
          e_fi = 16'(j);
          e_fd = inj[j];
        end
        e_err++;
      end
      s = {s[30:0], s[31]} ^ fold_bits(yf(mv[j]) ^ inj[j]);
    end

    @(negedge clk);
    seed = sd;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= DONE_E + 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      k = (e <= LAST_BUSY) ? (e - 1) / (ST + 1) : NV - 1;
      if (e <= LAST_BUSY) obs_vec[k] = vec_out;
      checks++;
      if (busy !== (e <= LAST_BUSY)) begin
        errors++;
        $display("FAIL %s busy edge=%0d got=%b exp=%b", nm, e, busy, (e <= LAST_BUSY));
      end
      checks++;
      if (done !== (e == DONE_E)) begin
        errors++;
        $display("FAIL %s done edge=%0d got=%b exp=%b", nm, e, done, (e == DONE_E));
      end
      checks++;
      if (vec_idx !== 16'(k) || vec_out !== mv[k]) begin
        errors++;
        $display("FAIL %s vec edge=%0d got idx=%0d vec=%h exp idx=%0d vec=%h", nm, e, vec_idx, vec_out, k, mv[k]);
      end
    end
    checks++;
    if (err_cnt !== e_err) begin
      errors++;
      $display("FAIL %s err_cnt got=%0d exp=%0d", nm, err_cnt, e_err);
    end
    checks++;
    if (first_idx !== e_fi || first_diff !== e_fd) begin
      errors++;
      $display("FAIL %s first got idx=%0d diff=%h exp idx=%0d diff=%h", nm, first_idx, first_diff, e_fi, e_fd);
    end
    checks++;
    if (pass !== (e_err == 0)) begin
      errors++;
      $display("FAIL %s pass got=%b exp=%b", nm, pass, (e_err == 0));
    end
    checks++;
    if (sig !== sig_expect(s)) begin
      errors++;
      $display("FAIL %s sig got=%h exp=%h", nm, sig, sig_expect(s));
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if (vec_out !== '0 || vec_idx !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        err_cnt !== 16'd0 || first_idx !== 16'd0 || first_diff !== '0 || sig !== sig_expect(32'hFFFF_FFFF)) begin
      errors++;
      $display("FAIL %s got vec=%h idx=%0d busy=%b done=%b pass=%b err=%0d fidx=%0d fdiff=%h sig=%h exp all zero sig=%h",
               nm, vec_out, vec_idx, busy, done, pass, err_cnt, first_idx, first_diff, sig, sig_expect(32'hFFFF_FFFF));
    end
  endtask

  task automatic test_reset();
    clear_inj();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_equal();
    clear_inj();
    run_check({$urandom, $urandom}, "equal");
  endtask

  task automatic test_vector_seq();
    logic [IN_W-1:0] exp2;
    clear_inj();
    run_check(64'h0, "vecseq");
    exp2 = 64'hD800_0000_0000_0000;
    checks++;
    if (obs_vec[0] !== 64'h0 || obs_vec[1] !== 64'h1 || obs_vec[2] !== exp2) begin
      errors++;
      $display("FAIL vecseq_const got %h %h %h exp 0 1 %h", obs_vec[0], obs_vec[1], obs_vec[2], exp2);
    end
  endtask

  task automatic test_single_mismatch();
    clear_inj();
    inj[2] = OUT_W'(1) << 5;
    run_check({$urandom, $urandom}, "single");
  endtask

  task automatic test_repeated_mismatch();
    clear_inj();
    inj[1] = OUT_W'(1) << 198;
    inj[3] = OUT_W'(1);
    run_check({$urandom, $urandom}, "repeated");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_inj();
      for (int j = 0; j < NV; j++)
        if ($urandom_range(0, 2) == 0) inj[j] = OUT_W'(1) << $urandom_range(0, OUT_W - 1);
      run_check({$urandom, $urandom}, "random");
    end
  endtask

  task automatic test_back_to_back();
    clear_inj();
    inj[0] = OUT_W'(3);
    run_check({$urandom, $urandom}, "b2b_fail");
    clear_inj();
    run_check({$urandom, $urandom}, "b2b_clean");
  endtask

  task automatic test_abort();
    int cyc, done_seen;
    clear_inj();
    @(negedge clk);
    seed = 64'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (vec_idx !== 16'd1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 50) begin
      errors++;
      $display("FAIL abort_wait got idx=%0d exp 1 within 50 cycles", vec_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || pass !== 1'b0 || vec_idx !== 16'd1) begin
      errors++;
      $display("FAIL abort_after got done/busy cycles=%0d pass=%b idx=%0d exp 0 0 1", done_seen, pass, vec_idx);
    end
  endtask

  task automatic test_async_reset();
    clear_inj();
    inj[0] = OUT_W'(1) << 77;
    @(negedge clk);
    seed = {$urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (err_cnt !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got err=%0d busy=%b exp 1 1", err_cnt, busy);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("areset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_one(input logic [OUT_W-1:0] yd, input logic [31:0] e_sig, input string nm);
    int cyc;
    y_dut1 = yd;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("FAIL %s timeout got no done exp done within 20 cycles", nm);
    end
    checks++;
    if (sig1 !== sig_expect(e_sig)) begin
      errors++;
      $display("FAIL %s sig got=%h exp=%h", nm, sig1, sig_expect(e_sig));
    end
    checks++;
    if (pass1 !== (yd == '0) || err_cnt1 !== ((yd == '0) ? 16'd0 : 16'd1) || vec_idx1 !== 16'd0) begin
      errors++;
      $display("FAIL %s status got pass=%b err=%0d idx=%0d exp pass=%b", nm, pass1, err_cnt1, vec_idx1, (yd == '0));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_misr();
    run_one('0, 32'hFFFF_FFFF, "misr_zero");
    run_one(OUT_W'(1), 32'hFFFF_FFFE, "misr_one");
  endtask

  initial begin
    clear_inj();
    test_reset();
    test_equal();
    test_vector_seq();
    test_single_mismatch();
    test_repeated_mismatch();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_misr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
